// File: rtl/call_stack_pkg.sv
// Shared definitions for the return-address stack: PC width and push/pop operation decode.
// The CPU datapath and PC register take PC_W from here as well.
package call_stack_pkg;

    localparam int unsigned PC_W = 10;

    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    function automatic stack_op_e decode_op(input logic push, input logic pop);
        stack_op_e op;
        case ({push, pop})
            2'b10:   op = OP_PUSH;
            2'b01:   op = OP_POP;
            2'b11:   op = OP_REPLACE;
            default: op = OP_IDLE;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/call_stack_stack_mem.sv
// Storage for the return-address stack: DEPTH x WIDTH registers, one synchronous
// write port, one asynchronous read port, no reset.
module stack_mem #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/call_stack.sv
// Hardware return-address stack: pointer, sticky overflow/underflow flags and
// push/pop decode around a register-array store; top of stack is combinational.
module call_stack
    import call_stack_pkg::*;
#(
    parameter int unsigned WIDTH = PC_W,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic [PTR_W:0]   count,
    output logic             ovf,
    output logic             udf
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W:0]   count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;

    stack_op_e        op;
    logic             is_empty, is_full;
    logic [PTR_W-1:0] top_idx;
    logic [PTR_W:0]   count_m1;
    logic             we;
    logic [PTR_W-1:0] waddr;
    logic [WIDTH-1:0] rdata;

    assign op       = decode_op(push, pop);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == FULL_CNT);
    assign count_m1 = count_q - 1'b1;
    // When empty this wraps to all ones, but the read result is masked below.
    assign top_idx  = count_m1[PTR_W-1:0];

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we      = 1'b0;
        waddr   = count_q[PTR_W-1:0];
        case (op)
            OP_PUSH: begin
                if (is_full) begin
                    ovf_d = 1'b1;
                end else begin
                    we      = 1'b1;
                    count_d = count_q + 1'b1;
                end
            end
            OP_POP: begin
                if (is_empty) begin
                    udf_d = 1'b1;
                end else begin
                    count_d = count_m1;
                end
            end
            OP_REPLACE: begin
                // Overwrite the top in place; on an empty stack this degenerates to a push at slot 0.
                we = 1'b1;
                if (is_empty) begin
                    count_d = count_q + 1'b1;
                end else begin
                    waddr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .clk     (clk),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (din),
        .raddr_i (top_idx),
        .rdata_o (rdata)
    );

    assign top   = is_empty ? '0 : rdata;
    assign empty = is_empty;
    assign full  = is_full;
    assign count = count_q;
    assign ovf   = ovf_q;
    assign udf   = udf_q;

endmodule

// File: tb/tb_call_stack.sv
// Directed bench for call_stack: a reference stack model fills a scoreboard of
// expected outputs per step, which is drained and compared against the DUT.
module tb_call_stack;

    localparam int unsigned W = 10;
    localparam int unsigned D = 16;

    logic         clk;
    logic         reset;
    logic         push;
    logic         pop;
    logic [W-1:0] din;
    logic [W-1:0] top;
    logic         empty;
    logic         full;
    logic [4:0]   count;
    logic         ovf;
    logic         udf;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct {
        int unsigned top_now;
        int unsigned cnt;
        int unsigned top_after;
        int unsigned ovf;
        int unsigned udf;
    } exp_t;

    exp_t        sb[$];
    int unsigned mstack[$];
    int unsigned movf = 0;
    int unsigned mudf = 0;

    call_stack #(.WIDTH(W), .DEPTH(D), .PTR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .top   (top),
        .empty (empty),
        .full  (full),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int unsigned mtop();
        return (mstack.size() == 0) ? 0 : mstack[mstack.size() - 1];
    endfunction

    // One clocked operation: model result queued at drive time, checked around the edge.
    task automatic step(input logic p, input logic q, input logic [W-1:0] d);
        exp_t e;
        push = p;
        pop  = q;
        din  = d;
        e.top_now = mtop();
        if (p && !q) begin
            if (mstack.size() < D) mstack.push_back(d);
            else movf = 1;
        end else if (!p && q) begin
            if (mstack.size() > 0) void'(mstack.pop_back());
            else mudf = 1;
        end else if (p && q) begin
            if (mstack.size() > 0) mstack[mstack.size() - 1] = d;
            else mstack.push_back(d);
        end
        e.cnt       = mstack.size();
        e.top_after = mtop();
        e.ovf       = movf;
        e.udf       = mudf;
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        chk("top_in_cycle", top, e.top_now);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        chk("count", count, e.cnt);
        chk("top",   top,   e.top_after);
        chk("ovf",   ovf,   e.ovf);
        chk("udf",   udf,   e.udf);
        chk("empty", empty, (e.cnt == 0) ? 1 : 0);
        chk("full",  full,  (e.cnt == D) ? 1 : 0);
    endtask

    initial begin
        reset = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        din   = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full",  full,  0);
        chk("rst_top",   top,   0);
        chk("rst_ovf",   ovf,   0);
        chk("rst_udf",   udf,   0);

        // LIFO order
        step(1, 0, 10'h005);
        step(1, 0, 10'h12A);
        step(1, 0, 10'h3FF);
        chk("lifo_count3", count, 3);
        chk("lifo_top3ff", top, 10'h3FF);
        step(0, 1, '0);
        step(0, 1, '0);
        step(0, 1, '0);
        chk("lifo_empty", empty, 1);

        // Simultaneous push+pop: replace in place, then on empty
        step(1, 0, 10'h011);
        step(1, 0, 10'h022);
        step(1, 1, 10'h033);
        chk("repl_top", top, 10'h033);
        chk("repl_count", count, 2);
        step(0, 1, '0);
        chk("repl_expose", top, 10'h011);
        step(0, 1, '0);
        step(1, 1, 10'h044);
        chk("repl_empty_top", top, 10'h044);
        chk("repl_empty_udf", udf, 0);
        step(0, 1, '0);

        // Overflow
        for (int i = 0; i < 16; i++) step(1, 0, W'(10'h100 + i));
        chk("ovf_full", full, 1);
        chk("ovf_top", top, 10'h10F);
        step(1, 0, 10'h200);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 16);
        step(1, 1, 10'h155);
        chk("ovf_repl_full", top, 10'h155);
        step(0, 1, '0);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_pop_count", count, 15);

        // Drain, then underflow
        for (int i = 0; i < 15; i++) step(0, 1, '0);
        step(0, 1, '0);
        chk("udf_set", udf, 1);
        chk("udf_top", top, 0);
        step(1, 0, 10'h0AA);
        chk("udf_sticky", udf, 1);
        chk("udf_push_top", top, 10'h0AA);

        // Asynchronous reset mid-operation at count=5
        for (int i = 0; i < 4; i++) step(1, 0, W'(10'h2C0 + i));
        chk("pre_arst_count", count, 5);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_top",   top,   0);
        chk("arst_ovf",   ovf,   0);
        chk("arst_udf",   udf,   0);
        mstack.delete();
        movf = 0;
        mudf = 0;
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("post_arst_count", count, 0);
        step(1, 0, 10'h3A5);
        chk("post_arst_top", top, 10'h3A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
